// File: rtl/adder_pkg.sv
// Shared definitions for the carry-lookahead adder: group width, group count
// helper and the generate/propagate pair type.
package adder_pkg;

  localparam int CLA_GROUP_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int num_groups(input int width);
    return width / CLA_GROUP_W;
  endfunction

endpackage

// File: rtl/cla_4bit_group.sv
// Combinational 4-bit carry-lookahead group: flat two-level carries,
// sum bits, and group generate/propagate for the second lookahead level.
module cla_4bit_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       gg,
  output logic       gp,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a direct sum-of-products; no carry feeds another carry.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

  assign s = p ^ c;

endmodule

// File: rtl/adder_4bit_lookahead.sv
// Registered carry-lookahead adder {carry, out} = a + b + cin built from 4-bit groups
// joined by a second-level group lookahead. Optional ADDER_GROUP_PG_EN adds gp/gg outputs.
module adder_4bit_lookahead
  import adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_GROUP_PG_EN
  output logic             gp,
  output logic             gg,
`endif
  output logic [WIDTH-1:0] out,
  output logic             carry
);

  localparam int NG = num_groups(WIDTH);

  generate
    if (WIDTH <= 0 || (WIDTH % CLA_GROUP_W) != 0) begin : g_bad_width
      $error("adder_4bit_lookahead: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  pg_t              grp_pg [NG];
  logic [NG-1:0]    grp_ci;
  logic [NG-1:0]    grp_co;
  logic [WIDTH-1:0] sum_p0;
  logic             carry_p0;

  // Second-level lookahead: each group carry-in is a flat OR of products over
  // lower groups' (GG, GP) and cin, so no group waits on another group's carry.
  always_comb begin
    logic acc;
    logic prod;
    grp_ci = '0;
    for (int k = 0; k < NG; k++) begin
      acc  = 1'b0;
      for (int j = 0; j < k; j++) begin
        prod = grp_pg[j].g;
        for (int m = j + 1; m < k; m++) prod = prod & grp_pg[m].p;
        acc = acc | prod;
      end
      prod = cin;
      for (int m = 0; m < k; m++) prod = prod & grp_pg[m].p;
      grp_ci[k] = acc | prod;
    end
  end

  for (genvar i = 0; i < NG; i++) begin : g_grp
    cla_4bit_group u_grp (
      .a  (a[i*CLA_GROUP_W +: CLA_GROUP_W]),
      .b  (b[i*CLA_GROUP_W +: CLA_GROUP_W]),
      .ci (grp_ci[i]),
      .s  (sum_p0[i*CLA_GROUP_W +: CLA_GROUP_W]),
      .gg (grp_pg[i].g),
      .gp (grp_pg[i].p),
      .co (grp_co[i])
    );
  end

  // The top group's carry-in comes from the lookahead, so its co is the adder carry-out.
  assign carry_p0 = grp_co[NG-1];

`ifdef ADDER_GROUP_PG_EN
  logic gg_p0;
  logic gp_p0;

  always_comb begin
    logic prod;
    gg_p0 = 1'b0;
    gp_p0 = 1'b1;
    for (int j = 0; j < NG; j++) begin
      prod = grp_pg[j].g;
      for (int m = j + 1; m < NG; m++) prod = prod & grp_pg[m].p;
      gg_p0 = gg_p0 | prod;
      gp_p0 = gp_p0 & grp_pg[j].p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gg <= 1'b0;
      gp <= 1'b0;
    end else begin
      gg <= gg_p0;
      gp <= gp_p0;
    end
  end
`endif

  // Stage p0 -> output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      carry <= 1'b0;
    end else begin
      out   <= sum_p0;
      carry <= carry_p0;
    end
  end

endmodule

// File: tb/tb_adder_4bit_lookahead.sv
// Directed and table-driven bench for adder_4bit_lookahead at WIDTH=4 and WIDTH=16.
module tb_adder_4bit_lookahead;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a, b;
  logic        cin;
  logic [3:0]  out;
  logic        carry;
  logic [15:0] a16, b16;
  logic        cin16;
  logic [15:0] out16;
  logic        carry16;
`ifdef ADDER_GROUP_PG_EN
  logic gp, gg, gp16, gg16;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  adder_4bit_lookahead #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
`ifdef ADDER_GROUP_PG_EN
    .gp(gp), .gg(gg),
`endif
    .out(out), .carry(carry)
  );

  adder_4bit_lookahead #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16),
`ifdef ADDER_GROUP_PG_EN
    .gp(gp16), .gg(gg16),
`endif
    .out(out16), .carry(carry16)
  );

  // Drive one vector, let one edge pass, compare {carry,out} one tick later.
  task automatic apply4(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                        input logic [4:0] exp, input string name);
    a = va; b = vb; cin = vc;
    @(posedge clk); #1;
    checks++;
    if ({carry, out} !== exp)
      $display("FAIL %s a=%h b=%h cin=%0d got=%h want=%h", name, va, vb, vc, {carry, out}, exp);
    else passed++;
`ifdef ADDER_GROUP_PG_EN
    checks++;
    if (carry !== (gg | (gp & vc)) || gp !== ((va ^ vb) == 4'hF) ||
        gg !== (({1'b0, va} + {1'b0, vb}) > 5'hF))
      $display("FAIL %s_pg a=%h b=%h gg=%0d gp=%0d carry=%0d", name, va, vb, gg, gp, carry);
    else passed++;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 4'hA; b = 4'h7; cin = 1'b1;
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({carry, out} !== 5'h00) $display("FAIL reset4 got=%h want=00", {carry, out});
      else passed++;
      checks++;
      if ({carry16, out16} !== 17'h0) $display("FAIL reset16 got=%h want=0", {carry16, out16});
      else passed++;
`ifdef ADDER_GROUP_PG_EN
      checks++;
      if ({gg, gp, gg16, gp16} !== 4'b0) $display("FAIL reset_pg got=%b want=0000", {gg, gp, gg16, gp16});
      else passed++;
`endif
    end
    rst = 1'b0;
    apply4(4'hA, 4'h7, 1'b1, 5'h12, "reset_release");
  endtask

  task automatic test_basic();
    apply4(4'h5, 4'h3, 1'b1, 5'h09, "basic");
    apply4(4'hF, 4'h1, 1'b0, 5'h10, "gen_carry");
    apply4(4'hF, 4'hF, 1'b1, 5'h1F, "all_ones_cin");
    apply4(4'hF, 4'h0, 1'b1, 5'h10, "full_prop_cin");
    apply4(4'hA, 4'h5, 1'b0, 5'h0F, "full_prop_nocin");
    apply4(4'h0, 4'h0, 1'b0, 5'h00, "zero");
  endtask

  task automatic test_back_to_back();
    logic [3:0] ra, rb;
    logic       rc;
    apply4(4'h4, 4'h1, 1'b1, 5'h06, "b2b_first");
    apply4(4'h9, 4'h3, 1'b1, 5'h0D, "b2b_second");
    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      apply4(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {4'b0, rc}, "b2b_rand");
    end
  endtask

  task automatic test_reset_midstream();
    a = 4'h8; b = 4'h8; cin = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({carry, out} !== 5'h00) $display("FAIL mid_reset got=%h want=00", {carry, out});
    else passed++;
    rst = 1'b0;
    apply4(4'h8, 4'h8, 1'b1, 5'h11, "after_mid_reset");
  endtask

  task automatic test_exhaustive4();
    for (int i = 0; i < 512; i++) begin
      logic [3:0] ea, eb;
      logic       ec;
      ea = 4'(i >> 5); eb = 4'(i >> 1); ec = 1'(i);
      apply4(ea, eb, ec, {1'b0, ea} + {1'b0, eb} + {4'b0, ec}, "exh4");
    end
  endtask

  task automatic test_wide16();
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] exp;
    for (int i = 0; i < 1004; i++) begin
      case (i)
        0: begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
        1: begin ra = 16'h5A5A; rb = 16'hA5A5; rc = 1'b1; end
        2: begin ra = 16'h0FFF; rb = 16'h0001; rc = 1'b0; end
        3: begin ra = 16'h00FF; rb = 16'h0000; rc = 1'b1; end
        default: begin ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); end
      endcase
      a16 = ra; b16 = rb; cin16 = rc;
      exp = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      @(posedge clk); #1;
      checks++;
      if ({carry16, out16} !== exp)
        $display("FAIL wide16 a=%h b=%h cin=%0d got=%h want=%h", ra, rb, rc, {carry16, out16}, exp);
      else passed++;
`ifdef ADDER_GROUP_PG_EN
      checks++;
      if (carry16 !== (gg16 | (gp16 & rc)) || gp16 !== ((ra ^ rb) == 16'hFFFF))
        $display("FAIL wide16_pg a=%h b=%h gg=%0d gp=%0d carry=%0d", ra, rb, gg16, gp16, carry16);
      else passed++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_midstream();
    test_exhaustive4();
    test_wide16();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/adder_4bit_lookahead.md
Name: adder_4bit_lookahead

Overview:
- Registered carry-lookahead adder computing out = a + b + cin, with carry-out.
- Default width 4 bits; the datapath is a single lookahead group.
- Wider builds chain 4-bit groups through a second-level group generate/propagate lookahead.
- Used as a low-latency arithmetic primitive feeding clocked datapath logic.

Parameters:
- WIDTH, 4, operand/sum width in bits. Must be a positive multiple of 4; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out  output  WIDTH  registered sum bits [WIDTH-1:0]
- carry  output  1  registered carry-out (sum bit WIDTH)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- rst=1 at a rising edge: out <= 0, carry <= 0. Reset dominates input activity.
- Latency: inputs sampled on rising edge N; result visible after edge N, held until the next edge.
- Throughput: one add per cycle. No handshake and no stall; every non-reset edge loads a new result.
- Arithmetic: {carry, out} = a + b + cin, all operands unsigned, computed at WIDTH+1 bits. No overflow flag; carry is the unsigned carry-out.
- Per bit: g[i] = a[i] & b[i], p[i] = a[i] ^ b[i], sum[i] = p[i] ^ c[i], with c[0] = cin.
- Within a 4-bit group, c[1..4] are flat two-level sum-of-products of g, p and the group carry-in. No ripple between bits, e.g. c2 = g1 | p1&g0 | p1&p0&c0.
- Each group exports GG = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0 and GP = p3&p2&p1&p0.
- Group carry-ins for WIDTH > 4 come from a second-level lookahead over (GG, GP), not from chaining group c4 outputs.
- Reset asserted mid-stream: that edge clears out/carry and discards the sampled inputs. The first edge after rst falls loads the current inputs normally.
- Boundaries:
  - Full propagate (a=~b) with cin=1 gives out=0, carry=1.
  - a=b=all-ones with cin=1 gives out=all-ones, carry=1.
- Out-of-reset values must never be X when inputs are known.

Optional Feature:
- Macro: ADDER_GROUP_PG_EN.
- Defined:
  - Adds output ports gp (1 bit) and gg (1 bit): top-level group propagate and generate over the full WIDTH, registered alongside out.
  - Both reset to 0 with the same 1-cycle latency.
  - carry == gg | (gp & cin_sampled) must hold.
- Undefined: ports gp/gg and their registers are absent. All other behaviour is identical.

Decomposition:
- Shared package adder_pkg:
  - localparam CLA_GROUP_W = 4
  - function num_groups(width) returning width/4
  - typedef pg_t: struct with g and p bits, used for group G/P signals
- One natural sub-module: cla_4bit_group.
  - Purely combinational.
  - Inputs a[3:0], b[3:0], ci. Outputs s[3:0], gg, gp, co.
- Top level instantiates WIDTH/4 groups, the second-level lookahead, and the output registers.

Test Plan:
- Reset: drive rst=1 with a=0xA, b=0x7, cin=1 for 2 edges -> out=0x0, carry=0. Release rst -> next edge out=0x2, carry=1.
- Basic add: a=0x5, b=0x3, cin=1 -> one edge later out=0x9, carry=0.
- Carry generate: a=0xF, b=0x1, cin=0 -> out=0x0, carry=1. With a=0xF, b=0xF, cin=1 -> out=0xF, carry=1.
- Full propagate chain: a=0xF, b=0x0, cin=1 -> out=0x0, carry=1. a=0xA, b=0x5, cin=0 -> out=0xF, carry=0.
- Back-to-back: a new operand pair every cycle for 10 random cycles (e.g. a=0x4, b=0x1, cin=1 then a=0x9, b=0x3, cin=1) -> each result appears exactly one edge after its inputs (0x6, carry 0 then 0xD, carry 0). Checked against a golden a+b+cin model.
- Exhaustive: all 512 combinations of (a, b, cin) at WIDTH=4, plus 1000 random vectors at WIDTH=16 -> {carry, out} matches the reference sum. With ADDER_GROUP_PG_EN defined, also check carry == gg | (gp & cin).
